// File: rtl/recon_pkg.sv
// Shared constants, state encoding and Q4.16 helpers for the recon_scan post-processing stage.
package recon_pkg;

    localparam int unsigned PIX_N = 9;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned Q_W   = 20;

    localparam logic signed [Q_W-1:0] Q_ONE  = 20'sh10000;
    localparam logic signed [Q_W-1:0] Q_HALF = 20'sh08000;
    localparam logic signed [Q_W-1:0] Q_MIN  = 20'sh80000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    // True when a Q4.16 value lies inside the nominal sigmoid range [0, 1].
    function automatic logic q_in_unit(input logic signed [Q_W-1:0] y);
        return !y[Q_W-1] && (y <= Q_ONE);
    endfunction

endpackage

// File: rtl/recon_cmp.sv
// Per-pixel decision: threshold bit, mismatch against the original pixel, and argmax update flag.
module recon_cmp
    import recon_pkg::*;
(
    input  logic signed [Q_W-1:0] y_i,
    input  logic signed [Q_W-1:0] max_val_i,
    input  logic signed [Q_W-1:0] thresh_i,
    input  logic                  x_bit_i,
    output logic                  pix_c_o,
    output logic                  mismatch_c_o,
    output logic                  upd_max_c_o
);

    // Strict greater-than so a tie keeps the earlier (lower) index.
    assign pix_c_o      = (y_i >= thresh_i);
    assign mismatch_c_o = pix_c_o ^ x_bit_i;
    assign upd_max_c_o  = (y_i > max_val_i);

endmodule

// File: rtl/recon_scan.sv
// Nine-cycle scan of sigmoid outputs into threshold reconstruction, argmax and error count.
// Optional feature macro: RECON_SCAN_ERRCNT_EN builds the X capture and error counter.
module recon_scan
    import recon_pkg::*;
#(
    parameter logic signed [Q_W-1:0] THRESH = Q_HALF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIX_N-1:0]      X,
    input  logic signed [Q_W-1:0] Y_0,
    input  logic signed [Q_W-1:0] Y_1,
    input  logic signed [Q_W-1:0] Y_2,
    input  logic signed [Q_W-1:0] Y_3,
    input  logic signed [Q_W-1:0] Y_4,
    input  logic signed [Q_W-1:0] Y_5,
    input  logic signed [Q_W-1:0] Y_6,
    input  logic signed [Q_W-1:0] Y_7,
    input  logic signed [Q_W-1:0] Y_8,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIX_N-1:0]      recon,
    output logic [IDX_W-1:0]      max_idx,
    output logic signed [Q_W-1:0] max_val,
    output logic [IDX_W-1:0]      err_count
);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic signed [Q_W-1:0] y_q [PIX_N];
    logic signed [Q_W-1:0] y_d [PIX_N];
    logic [PIX_N-1:0]      recon_q, recon_d;
    logic [IDX_W-1:0]      max_idx_q, max_idx_d;
    logic signed [Q_W-1:0] max_val_q, max_val_d;

    logic [IDX_W-1:0]      pos;
    logic signed [Q_W-1:0] y_cur;
    logic                  x_bit;
    logic                  pix;
    logic                  mismatch;
    logic                  upd_max;

`ifdef RECON_SCAN_ERRCNT_EN
    logic [PIX_N-1:0] x_q, x_d;
    logic [IDX_W-1:0] err_q, err_d;
    assign x_bit = x_q[pos];
`else
    logic unused_errcnt;
    assign x_bit         = 1'b0;
    assign unused_errcnt = ^{X, mismatch};
`endif

    // Y_k pairs with bit 8-k of the pattern.
    assign pos   = IDX_W'(PIX_N - 1) - idx_q;
    assign y_cur = y_q[idx_q];

    recon_cmp u_cmp (
        .y_i          (y_cur),
        .max_val_i    (max_val_q),
        .thresh_i     (THRESH),
        .x_bit_i      (x_bit),
        .pix_c_o      (pix),
        .mismatch_c_o (mismatch),
        .upd_max_c_o  (upd_max)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        y_d       = y_q;
        recon_d   = recon_q;
        max_idx_d = max_idx_q;
        max_val_d = max_val_q;
`ifdef RECON_SCAN_ERRCNT_EN
        x_d       = x_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d       = '{Y_0, Y_1, Y_2, Y_3, Y_4, Y_5, Y_6, Y_7, Y_8};
                    idx_d     = '0;
                    recon_d   = '0;
                    max_idx_d = '0;
                    max_val_d = Q_MIN;
`ifdef RECON_SCAN_ERRCNT_EN
                    x_d       = X;
                    err_d     = '0;
`endif
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                recon_d[pos] = pix;
                if (upd_max) begin
                    max_val_d = y_cur;
                    max_idx_d = idx_q;
                end
`ifdef RECON_SCAN_ERRCNT_EN
                if (mismatch) begin
                    err_d = err_q + IDX_W'(1);
                end
`endif
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(PIX_N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            y_q       <= '{default: '0};
            recon_q   <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
`ifdef RECON_SCAN_ERRCNT_EN
            x_q       <= '0;
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            y_q       <= y_d;
            recon_q   <= recon_d;
            max_idx_q <= max_idx_d;
            max_val_q <= max_val_d;
`ifdef RECON_SCAN_ERRCNT_EN
            x_q       <= x_d;
            err_q     <= err_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign recon     = recon_q;
    assign max_idx   = max_idx_q;
    assign max_val   = max_val_q;
`ifdef RECON_SCAN_ERRCNT_EN
    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_recon_scan.sv
// Directed bench for recon_scan: reset, thresholds, argmax ties, backpressure, negatives, mid-scan reset.
module tb_recon_scan;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [8:0]        X;
    logic signed [19:0] y [9];
    logic              out_valid;
    logic              out_ready;
    logic [8:0]        recon;
    logic [3:0]        max_idx;
    logic signed [19:0] max_val;
    logic [3:0]        err_count;

    int n_chk;
    int n_fail;
    int n;

    recon_scan dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y_0       (y[0]),
        .Y_1       (y[1]),
        .Y_2       (y[2]),
        .Y_3       (y[3]),
        .Y_4       (y[4]),
        .Y_5       (y[5]),
        .Y_6       (y[6]),
        .Y_7       (y[7]),
        .Y_8       (y[8]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .recon     (recon),
        .max_idx   (max_idx),
        .max_val   (max_val),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Error counter reads zero when the feature is not built.
    function automatic logic [31:0] e_err(input int cnt);
`ifdef RECON_SCAN_ERRCNT_EN
        return 32'(cnt);
`else
        return 32'(cnt * 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            step();
            cyc++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X         = '0;
        for (int k = 0; k < 9; k++) y[k] = '0;
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready",  32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_recon",     32'(recon), 32'h0);
        chk("rst_max_idx",   32'(max_idx), 32'h0);
        chk("rst_max_val",   32'(max_val), 32'h0);
        chk("rst_err",       32'(err_count), 32'h0);

        // All equal above threshold: tie keeps index 0.
        X = 9'h1FF;
        for (int k = 0; k < 9; k++) y[k] = 20'sh0C000;
        accept();
        chk("basic_busy", 32'(in_ready), 32'h0);
        wait_done(n);
        chk("basic_latency", 32'(n), 32'd9);
        chk("basic_recon",   32'(recon), 32'h1FF);
        chk("basic_err",     32'(err_count), e_err(0));
        chk("basic_max_idx", 32'(max_idx), 32'h0);
        chk("basic_max_val", 32'(max_val), 32'(20'sh0C000));
        release_out();
        chk("basic_idle_in_ready", 32'(in_ready), 32'h1);
        chk("basic_idle_out_valid", 32'(out_valid), 32'h0);

        // Threshold boundary: exactly 0.5 sets, one LSB below clears.
        X = 9'h000;
        for (int k = 0; k < 9; k++) y[k] = '0;
        y[0] = 20'sh08000;
        y[1] = 20'sh07FFF;
        y[4] = 20'sh0F000;
        accept();
        wait_done(n);
        chk("thr_latency", 32'(n), 32'd9);
        chk("thr_recon",   32'(recon), 32'h110);
        chk("thr_err",     32'(err_count), e_err(2));
        chk("thr_max_idx", 32'(max_idx), 32'h4);
        chk("thr_max_val", 32'(max_val), 32'(20'sh0F000));
        release_out();

        // Backpressure with a new item held by the producer during DONE.
        X = 9'h1FF;
        for (int k = 0; k < 9; k++) y[k] = 20'sh0C000;
        accept();
        wait_done(n);
        chk("bp_latency", 32'(n), 32'd9);
        X = 9'h0A5;
        for (int k = 0; k < 8; k++) y[k] = 20'shFFF00;
        y[8] = 20'shFFF80;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_in_ready",  32'(in_ready), 32'h0);
            chk("bp_recon",     32'(recon), 32'h1FF);
            chk("bp_max_val",   32'(max_val), 32'(20'sh0C000));
            chk("bp_err",       32'(err_count), e_err(0));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle_in_ready",  32'(in_ready), 32'h1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'h0);
        step();
        in_valid = 1'b0;
        chk("bp_accepted", 32'(in_ready), 32'h0);

        // Negative inputs: all below threshold, argmax picks the least negative.
        wait_done(n);
        chk("neg_latency", 32'(n), 32'd9);
        chk("neg_recon",   32'(recon), 32'h0);
        chk("neg_max_idx", 32'(max_idx), 32'h8);
        chk("neg_max_val", 32'(max_val), 32'(20'shFFF80));
        chk("neg_err",     32'(err_count), e_err(4));
        release_out();

        // Reset at SCAN idx 4, with in_valid also high on the reset edge.
        X = 9'h1FF;
        for (int k = 0; k < 9; k++) y[k] = 20'sh0C000;
        accept();
        for (int i = 0; i < 4; i++) step();
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mrst_in_ready",  32'(in_ready), 32'h1);
        chk("mrst_out_valid", 32'(out_valid), 32'h0);
        chk("mrst_recon",     32'(recon), 32'h0);
        chk("mrst_max_val",   32'(max_val), 32'h0);
        step();
        chk("mrst_still_idle", 32'(in_ready), 32'h1);

        // Ramp Y_k = k/8 after the aborted item.
        X = 9'h155;
        for (int k = 0; k < 9; k++) y[k] = 20'(k * 32'h2000);
        accept();
        wait_done(n);
        chk("ramp_latency", 32'(n), 32'd9);
        chk("ramp_recon",   32'(recon), 32'h01F);
        chk("ramp_max_idx", 32'(max_idx), 32'h8);
        chk("ramp_max_val", 32'(max_val), 32'(20'sh10000));
        chk("ramp_err",     32'(err_count), e_err(4));
        release_out();
        chk("ramp_idle", 32'(in_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/recon_scan.md
# recon_scan

Sequential post-processing stage that sits directly downstream of the sigmoid outputs of the 9-input, 9-output network. Accepts one inference result (Y_0..Y_8 plus the original 9-bit input X) through a valid/ready handshake. Scans the nine Q4.16 probabilities over nine cycles to produce three results, which it holds for a downstream consumer:
- a thresholded 9-bit reconstruction;
- an argmax index and value;
- a reconstruction-error count.

## Interface
Parameters:
- THRESH, 20'sh08000: signed Q4.16 decision threshold (0.5). A pixel is 1 when Y_k >= THRESH.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  X and Y_0..Y_8 are valid this cycle.
- in_ready  out  1  block can accept; high only in IDLE.
- X  in  9  original input pattern. X[8] pairs with Y_0 and X[0] pairs with Y_8.
- Y_0..Y_8  in  20 each, signed  sigmoid outputs, Q4.16.
- out_valid  out  1  results valid; high only in DONE.
- out_ready  in  1  consumer accepts results.
- recon  out  9  thresholded pattern; recon[8-k] = (Y_k >= THRESH).
- max_idx  out  4  k of the largest Y_k, 0..8.
- max_val  out  20, signed  value of that largest Y_k.
- err_count  out  4  popcount(recon XOR X), 0..9.

## Operation
- The FSM has three states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, register X and all nine Y_k.
  - Clear the working recon and err_count; set idx = 0, max_val = 20'sh80000 and max_idx = 0.
  - Go to SCAN.
- SCAN processes the registered Y_idx each cycle:
  - recon[8-idx] <= (Y_idx >= THRESH), using a signed compare.
  - err_count increments when that bit differs from X[8-idx].
  - If Y_idx > max_val (strictly greater), update max_val and max_idx. A tie keeps the lower index.
  - idx increments. When idx == 8 is processed, go to DONE.
- DONE:
  - out_valid = 1. recon, max_idx, max_val and err_count are held stable.
  - When out_ready is high, go to IDLE.
- Inputs are sampled only on the accepting edge. X/Y changes during SCAN or DONE are ignored.
- Arithmetic:
  - Compares are 20-bit signed. No arithmetic widening is needed.
  - err_count is 4 bits and never exceeds 9, so it cannot wrap.
  - Negative Y_k (out-of-range sigmoid) is legal: it yields recon bit 0 and participates in argmax normally.

## Timing
- The accepting edge is E0. SCAN occupies the edges E1..E9; out_valid is high from after E9.
- Latency: 9 edges from accept to out_valid.
- With out_ready held high, DONE lasts one cycle. in_ready rises the cycle after the out_ready handshake; there is no IDLE bypass.
- Minimum accept-to-accept interval: 11 cycles.
- out_valid stays high until out_ready. Outputs must not change while out_valid is high.
- in_ready and out_valid are decoded directly from the state register. No combinational path runs from in_valid or out_ready to them.
- Reset behaviour:
  - Values: state = IDLE, in_ready = 1, out_valid = 0, recon = 0, max_idx = 0, max_val = 0, err_count = 0.
  - Reset in SCAN or DONE aborts the current item; no partial result is presented.
- Simultaneous events:
  - in_valid arriving in SCAN or DONE is not accepted; the producer must hold it.
  - rst together with in_valid: reset wins and nothing is captured.

## Configuration
- RECON_SCAN_ERRCNT_EN:
  - Defined: the error counter and the X capture register are built; err_count behaves as described.
  - Undefined: both are removed, err_count is tied to 0, and X is ignored. recon, argmax and handshake are unchanged.

## Structure
- Package recon_pkg holds:
  - the Q4.16 constants Q_ONE = 20'sh10000, Q_HALF = 20'sh08000 and Q_MIN = 20'sh80000;
  - PIX_N = 9 and IDX_W = 4;
  - the state enum {IDLE, SCAN, DONE}.
- One sub-module, recon_cmp, is combinational. It takes Y_idx, the current max_val, X bit and THRESH. It returns the recon bit, the mismatch flag and the update-max flag.
- The top module holds the FSM, the capture registers, the index counter and the output registers.

## Test plan
- Reset, then idle: after rst, in_ready = 1, out_valid = 0 and all outputs are 0.
- Basic case:
  - Stimulus: X = 9'h1FF, all Y = 20'sh0C000.
  - Response: recon = 9'h1FF, err_count = 0, max_idx = 0, max_val = 20'sh0C000 (tie keeps index 0), out_valid 9 edges after accept.
- Threshold edge and errors:
  - Stimulus: X = 9'h000, Y_0 = 20'sh08000, Y_1 = 20'sh07FFF, Y_4 = 20'sh0F000, others 0.
  - Response: recon = 9'h110, err_count = 2, max_idx = 4, max_val = 20'sh0F000.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE. Outputs stay stable and in_ready stays 0; in_valid held by the producer is accepted one cycle after the out_ready handshake.
- Negative inputs: all Y = 20'shFFF00 except Y_8 = 20'shFFF80. Response: recon = 0, max_idx = 8.
- Mid-scan reset: assert rst at SCAN idx 4. Next cycle is IDLE with out_valid = 0; a new item then completes correctly.
